mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Memory/IO responder on the bus driven by the multi-cycle CPU controller.
- Accepts MemRead/MemWrite requests with RAMCtrl access type and returns MIO_ready over a 4-phase handshake.
- Performs big-endian word/half lane steering, sign/zero extension and byte swapping.
- Routes each access either to a byte-enabled synchronous RAM or to a peripheral req/ack bus with timeout.

Parameters:
- RAM_AW, 12, RAM word-address width.
- RD_LAT, 1, RAM read latency in cycles after the ram_en cycle (>=1).
- IO_BASE, 4'hE, value of addr[31:28] that selects the IO region.
- TIMEOUT, 255, max cycles waiting for io_ack (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mem_read  in  1  read request (instruction or data)
- mem_write  in  1  write request
- ram_ctrl  in  3  access type: 000 Full, 001 Fullx, 010 Half, 011 Halfx, 100 Halfu, 101 Halfux; 110/111 treated as Full
- addr  in  32  byte address
- wdata  in  32  store data; halves taken from wdata[15:0]
- rdata  out  32  extended/steered load data
- mio_ready  out  1  transaction complete
- err  out  1  misaligned access or IO timeout; valid while mio_ready=1
- ram_en  out  1  RAM access strobe
- ram_we  out  4  byte write enables; bit3 = bits[31:24]
- ram_addr  out  RAM_AW  addr[RAM_AW+1:2]
- ram_din  out  32  lane-positioned write data
- ram_dout  in  32  RAM read data
- io_req  out  1  peripheral request
- io_we  out  1  peripheral write
- io_be  out  4  peripheral byte enables
- io_addr  out  32  byte address
- io_wdata  out  32  lane-positioned write data
- io_rdata  in  32  peripheral read data
- io_ack  in  1  peripheral completion

Behaviour:
- Reset (rst, asynchronous, active-high; clock clk):
  - state IDLE.
  - All outputs 0: rdata, mio_ready, err, ram_en, ram_we, ram_addr, ram_din, io_*.
  - Reset mid-transaction aborts it and drops io_req immediately.
- FSM states: IDLE, ACC, RWAIT, IOREQ, DONE.
- IDLE: at an edge where mem_read or mem_write=1, latch addr, wdata, ram_ctrl and direction. If both are high, write wins.
  - Misaligned access -> DONE directly: Full/Fullx with addr[1:0]!=0, or any Half type with addr[0]=1. No RAM/IO activity; rdata=0, err=1.
  - addr[31:28]==IO_BASE -> IOREQ; otherwise -> ACC.
- Lane steering (big-endian):
  - Word = bytes B0..B3 at bits [31:24]..[7:0].
  - Half at addr[1]=0 uses bits[31:16], be=1100; at addr[1]=1 uses bits[15:0], be=0011.
  - Full be=1111.
- x variants reverse byte order within the accessed unit, on both load and store.
- Load extension:
  - Half/Halfx: sign-extend the 16-bit result.
  - Halfu/Halfux: zero-extend.
  - Full/Fullx: no extension.
- ACC (1 cycle): ram_en=1. On write, ram_we=be and ram_din=steered data, then -> DONE. On read, ram_we=0, then -> RWAIT.
- RWAIT: count RD_LAT cycles. On the last one, capture the processed ram_dout into rdata and go to DONE.
  - Read: mio_ready rises at edge E+1+RD_LAT, where E is the accepting edge.
  - Write: mio_ready rises at E+2.
- IOREQ:
  - io_req=1, with io_we, io_be, io_addr, io_wdata stable until io_ack.
  - On io_ack: capture processed io_rdata (reads), drop io_req, -> DONE.
  - If no ack after TIMEOUT cycles: drop io_req, rdata=0, err=1, -> DONE.
- DONE: mio_ready=1, with rdata/err held. Once mem_read=mem_write=0: mio_ready=0, err=0, -> IDLE.
- rdata holds its value until the next load completes; it is not cleared in IDLE.
- Requests that change while busy are ignored (latched values are used).
- ram_we and ram_en are 0 outside ACC; io_req is 0 outside IOREQ.

Test Plan:
- Full read, RD_LAT=1: RAM word at 0x100 = 0x11223344; read addr=0x100, ram_ctrl=000 -> ram_en one cycle, ram_addr=0x40, mio_ready at E+2, rdata=0x11223344; drop mem_read -> mio_ready=0 next edge.
- Half loads on word 0x8001C0DE: addr offset 0 -> Half 0xFFFF8001, Halfu 0x00008001; offset 2 -> Half 0xFFFFC0DE; Halfx offset 2 -> 0xFFFFDEC0; Halfux offset 0 -> 0x00000180.
- Stores: Half, wdata=0xAAAABEEF, addr offset 2 -> ram_we=0011, ram_din[15:0]=0xBEEF; Fullx, wdata=0x11223344 -> ram_we=1111, ram_din=0x44332211; mio_ready at E+2.
- Misaligned: Full read at 0x102 -> no ram_en, mio_ready at E+1, err=1, rdata=0.
- IO: read at 0xE0000010, io_ack after 3 cycles with io_rdata=0x12345678 -> io_req high 3 cycles, rdata=0x12345678, err=0. With no ack and TIMEOUT=4 -> io_req drops after 4 cycles, err=1.
- Reset asserted during IOREQ -> io_req and mio_ready drop immediately, state IDLE; a new read completes normally after release.

Source files
------------

// File: rtl/mem_io_responder_if.sv
// CPU-side memory/IO bus: request, access type, data and 4-phase completion.
interface mem_io_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  ram_ctrl;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mio_ready;
  logic        err;

  // CPU controller side
  modport master (
    output mem_read, mem_write, ram_ctrl, addr, wdata,
    input  rdata, mio_ready, err
  );

  // Responder side
  modport slave (
    input  mem_read, mem_write, ram_ctrl, addr, wdata,
    output rdata, mio_ready, err
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory/IO responder: big-endian lane steering, load extension, byte swap,
// and routing to a byte-enabled sync RAM or a req/ack peripheral bus.
module mem_io_responder #(
  parameter int          RAM_AW  = 12,
  parameter int          RD_LAT  = 1,
  parameter logic [3:0]  IO_BASE = 4'hE,
  parameter int          TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_io_responder_if.slave bus,
  output logic              o_ram_en,
  output logic [3:0]        o_ram_we,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [31:0]       o_ram_din,
  input  logic [31:0]       i_ram_dout,
  output logic              o_io_req,
  output logic              o_io_we,
  output logic [3:0]        o_io_be,
  output logic [31:0]       o_io_addr,
  output logic [31:0]       o_io_wdata,
  input  logic [31:0]       i_io_rdata,
  input  logic              i_io_ack
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACC   = 3'd1;
  localparam logic [2:0] S_RWAIT = 3'd2;
  localparam logic [2:0] S_IOREQ = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [15:0] RD_LAST = 16'(RD_LAT - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  r_state;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [2:0]  r_ctrl;
  logic        r_we, r_mio_ready, r_err;
  logic [15:0] r_cnt;

  logic        w_half, w_swap, w_req_half, w_misal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [15:0] w_wh;

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Pick the accessed unit out of a raw word, swap for x types, then extend.
  function automatic logic [31:0] load_fmt(input logic [31:0] raw,
                                           input logic [2:0] ctl,
                                           input logic a1);
    logic [15:0] h;
    h = a1 ? raw[15:0] : raw[31:16];
    if (ctl == 3'b011 || ctl == 3'b101) h = {h[7:0], h[15:8]};
    case (ctl)
      3'b001:         return swap32(raw);
      3'b010, 3'b011: return {{16{h[15]}}, h};
      3'b100, 3'b101: return {16'h0, h};
      default:        return raw;
    endcase
  endfunction

  // Access-type decode of the latched request; 110/111 fall back to Full.
  assign w_half     = r_ctrl inside {3'b010, 3'b011, 3'b100, 3'b101};
  assign w_swap     = r_ctrl inside {3'b001, 3'b011, 3'b101};
  assign w_be       = !w_half ? 4'hF : (r_addr[1] ? 4'h3 : 4'hC);
  assign w_req_half = bus.ram_ctrl inside {3'b010, 3'b011, 3'b100, 3'b101};
  assign w_misal    = w_req_half ? bus.addr[0] : (bus.addr[1:0] != 2'b00);

  // Store data positioned onto the big-endian byte lanes.
  always_comb begin
    w_wh    = w_swap ? {r_wdata[7:0], r_wdata[15:8]} : r_wdata[15:0];
    w_wdata = w_swap ? swap32(r_wdata) : r_wdata;
    if (w_half) w_wdata = r_addr[1] ? {16'h0, w_wh} : {w_wh, 16'h0};
  end

  // Strobes are decoded from state so reset drops them immediately.
  assign o_ram_en   = (r_state == S_ACC);
  assign o_ram_we   = (o_ram_en && r_we) ? w_be : 4'h0;
  assign o_ram_addr = r_addr[RAM_AW+1:2];
  assign o_ram_din  = w_wdata;
  assign o_io_req   = (r_state == S_IOREQ);
  assign o_io_we    = o_io_req & r_we;
  assign o_io_be    = o_io_req ? w_be : 4'h0;
  assign o_io_addr  = r_addr;
  assign o_io_wdata = w_wdata;

  assign bus.rdata     = r_rdata;
  assign bus.mio_ready = r_mio_ready;
  assign bus.err       = r_err;

  // Transaction FSM: latch request, run RAM or IO access, hold result until released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_ctrl      <= '0;
      r_we        <= 1'b0;
      r_mio_ready <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.mem_read || bus.mem_write) begin
          r_addr  <= bus.addr;
          r_wdata <= bus.wdata;
          r_ctrl  <= bus.ram_ctrl;
          r_we    <= bus.mem_write;
          r_cnt   <= '0;
          if (w_misal) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (bus.addr[31:28] == IO_BASE) begin
            r_state <= S_IOREQ;
          end else begin
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          r_cnt   <= '0;
          r_state <= r_we ? S_DONE : S_RWAIT;
        end
        // Read data is captured on the last latency cycle, with ready in the same edge.
        S_RWAIT: if (r_cnt == RD_LAST) begin
          r_rdata     <= load_fmt(i_ram_dout, r_ctrl, r_addr[1]);
          r_mio_ready <= 1'b1;
          r_state     <= S_DONE;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
        S_IOREQ: if (i_io_ack) begin
          if (!r_we) r_rdata <= load_fmt(i_io_rdata, r_ctrl, r_addr[1]);
          r_state <= S_DONE;
        end else if (r_cnt == TO_LAST) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
          r_state <= S_DONE;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
        // Raise ready once, then wait for the CPU to drop its request.
        S_DONE: if (!r_mio_ready) begin
          r_mio_ready <= 1'b1;
        end else if (!bus.mem_read && !bus.mem_write) begin
          r_mio_ready <= 1'b0;
          r_err       <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with a small sync RAM model and a
// hand-driven peripheral ack.
module tb_mem_io_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        io_req, io_we, io_ack;
  logic [3:0]  io_be;
  logic [31:0] io_addr, io_wdata, io_rdata;

  int checks = 0;
  int failures = 0;

  // Captured per-transaction observations
  logic [31:0] t_cyc, t_en, t_io, t_din, t_rdata, t_ioaddr, t_iowd;
  logic [3:0]  t_we, t_iobe;
  logic        t_err, t_iowe, t_rel;

  logic [31:0] mem [0:4095];

  mem_io_responder_if bus();

  mem_io_responder #(.RAM_AW(12), .RD_LAT(1), .IO_BASE(4'hE), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .o_ram_en   (ram_en),
    .o_ram_we   (ram_we),
    .o_ram_addr (ram_addr),
    .o_ram_din  (ram_din),
    .i_ram_dout (ram_dout),
    .o_io_req   (io_req),
    .o_io_we    (io_we),
    .o_io_be    (io_be),
    .o_io_addr  (io_addr),
    .o_io_wdata (io_wdata),
    .i_io_rdata (io_rdata),
    .i_io_ack   (io_ack)
  );

  always #5 clk = ~clk;

  // Sync RAM, one cycle read latency; preloaded while reset is held.
  always @(posedge clk) begin
    if (rst) begin
      mem[12'h040] <= 32'h11223344;
      mem[12'h041] <= 32'h8001C0DE;
      mem[12'h042] <= 32'h00000000;
      ram_dout     <= 32'h0;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for mio_ready, then release it.
  // t_cyc counts edges after the accepting edge; 0xFFFFFFFF means no ready.
  task automatic txn(input logic rd, input logic wr, input logic [2:0] ctl,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int ack_after, input logic [31:0] iord);
    int ion;
    ion = 0;
    t_cyc = 32'hFFFFFFFF; t_en = 0; t_io = 0; t_we = 0; t_din = 0;
    t_rdata = 32'hx; t_err = 1'bx;
    bus.mem_read = rd; bus.mem_write = wr; bus.ram_ctrl = ctl;
    bus.addr = a; bus.wdata = wd; io_rdata = iord;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ram_en) begin
        t_en = t_en + 1; t_we = ram_we; t_din = ram_din;
      end
      if (io_req) begin
        ion++;
        if (ion == 1) begin
          t_ioaddr = io_addr; t_iowe = io_we; t_iobe = io_be; t_iowd = io_wdata;
        end
        io_ack = (ack_after > 0) && (ion == ack_after);
      end else begin
        io_ack = 1'b0;
      end
      if (bus.mio_ready) begin
        t_cyc = 32'(i - 1); t_rdata = bus.rdata; t_err = bus.err;
        break;
      end
    end
    t_io = 32'(ion);
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; io_ack = 1'b0;
    tick();
    t_rel = bus.mio_ready;
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_read = 0; bus.mem_write = 0; bus.ram_ctrl = 0; bus.addr = 0; bus.wdata = 0;
    io_ack = 0; io_rdata = 0;
    repeat (3) tick();
    chk("rst_ready", 32'(bus.mio_ready), 32'd0);
    chk("rst_err",   32'(bus.err), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_ramen", 32'(ram_en), 32'd0);
    chk("rst_ramwe", 32'(ram_we), 32'd0);
    chk("rst_ioreq", 32'(io_req), 32'd0);
    chk("rst_iobe",  32'(io_be), 32'd0);
    chk("rst_ioaddr", io_addr, 32'd0);
    rst = 1'b0;
    tick();

    // Full read with edge-by-edge timing
    bus.mem_read = 1; bus.ram_ctrl = 3'b000; bus.addr = 32'h100;
    tick();
    chk("fr_en_E",    32'(ram_en), 32'd1);
    chk("fr_addr",    32'(ram_addr), 32'h40);
    chk("fr_we",      32'(ram_we), 32'd0);
    chk("fr_rdy_E",   32'(bus.mio_ready), 32'd0);
    tick();
    chk("fr_en_E1",   32'(ram_en), 32'd0);
    chk("fr_rdy_E1",  32'(bus.mio_ready), 32'd0);
    tick();
    chk("fr_rdy_E2",  32'(bus.mio_ready), 32'd1);
    chk("fr_rdata",   bus.rdata, 32'h11223344);
    chk("fr_err",     32'(bus.err), 32'd0);
    bus.mem_read = 0;
    tick();
    chk("fr_release", 32'(bus.mio_ready), 32'd0);

    // Half-type loads on 0x8001C0DE
    txn(1, 0, 3'b010, 32'h104, 0, 0, 0); chk("half_o0",   t_rdata, 32'hFFFF8001);
    chk("half_cyc", t_cyc, 32'd2);
    txn(1, 0, 3'b100, 32'h104, 0, 0, 0); chk("halfu_o0",  t_rdata, 32'h00008001);
    txn(1, 0, 3'b010, 32'h106, 0, 0, 0); chk("half_o2",   t_rdata, 32'hFFFFC0DE);
    txn(1, 0, 3'b011, 32'h106, 0, 0, 0); chk("halfx_o2",  t_rdata, 32'hFFFFDEC0);
    txn(1, 0, 3'b101, 32'h104, 0, 0, 0); chk("halfux_o0", t_rdata, 32'h00000180);
    txn(1, 0, 3'b001, 32'h100, 0, 0, 0); chk("fullx_ld",  t_rdata, 32'h44332211);
    chk("fullx_rel", 32'(t_rel), 32'd0);

    // Stores
    txn(0, 1, 3'b010, 32'h10A, 32'hAAAABEEF, 0, 0);
    chk("sth_we", 32'(t_we), 32'h3); chk("sth_din", t_din, 32'h0000BEEF);
    chk("sth_cyc", t_cyc, 32'd2); chk("sth_en", t_en, 32'd1);
    txn(1, 0, 3'b000, 32'h108, 0, 0, 0); chk("sth_readback", t_rdata, 32'h0000BEEF);
    txn(0, 1, 3'b001, 32'h10C, 32'h11223344, 0, 0);
    chk("stx_we", 32'(t_we), 32'hF); chk("stx_din", t_din, 32'h44332211);
    chk("stx_cyc", t_cyc, 32'd2);
    txn(0, 1, 3'b011, 32'h110, 32'h00001234, 0, 0);
    chk("sthx_we", 32'(t_we), 32'hC); chk("sthx_din", t_din, 32'h34120000);
    txn(1, 1, 3'b000, 32'h114, 32'hDEADBEEF, 0, 0);
    chk("both_write", 32'(t_we), 32'hF);

    // Misaligned accesses
    txn(1, 0, 3'b000, 32'h102, 0, 0, 0);
    chk("mis_cyc", t_cyc, 32'd1); chk("mis_en", t_en, 32'd0);
    chk("mis_err", 32'(t_err), 32'd1); chk("mis_rdata", t_rdata, 32'd0);
    chk("mis_err_rel", 32'(bus.err), 32'd0);
    txn(1, 0, 3'b000, 32'h100, 0, 0, 0);
    txn(1, 0, 3'b100, 32'h101, 0, 0, 0);
    chk("mish_err", 32'(t_err), 32'd1); chk("mish_rdata", t_rdata, 32'd0);

    // IO read acked after 3 cycles
    txn(1, 0, 3'b000, 32'hE0000010, 0, 3, 32'h12345678);
    chk("io_cycles", t_io, 32'd3); chk("io_rdata", t_rdata, 32'h12345678);
    chk("io_err", 32'(t_err), 32'd0); chk("io_addr", t_ioaddr, 32'hE0000010);
    chk("io_we", 32'(t_iowe), 32'd0); chk("io_be", 32'(t_iobe), 32'hF);
    chk("io_ramen", t_en, 32'd0);
    // IO Halfx write
    txn(0, 1, 3'b011, 32'hE0000022, 32'h0000CAFE, 1, 0);
    chk("iow_we", 32'(t_iowe), 32'd1); chk("iow_be", 32'(t_iobe), 32'h3);
    chk("iow_wdata", t_iowd, 32'h0000FECA); chk("iow_err", 32'(t_err), 32'd0);
    // IO timeout
    txn(1, 0, 3'b000, 32'hE0000010, 0, 0, 32'h0);
    chk("to_cycles", t_io, 32'd4); chk("to_err", 32'(t_err), 32'd1);
    chk("to_rdata", t_rdata, 32'd0);

    // Reset during IOREQ
    bus.mem_read = 1; bus.ram_ctrl = 3'b000; bus.addr = 32'hE0000020;
    tick(); tick();
    chk("rio_req_before", 32'(io_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rio_req_after", 32'(io_req), 32'd0);
    chk("rio_ready", 32'(bus.mio_ready), 32'd0);
    bus.mem_read = 0;
    tick();
    rst = 1'b0;
    tick();
    txn(1, 0, 3'b000, 32'h100, 0, 0, 0);
    chk("rio_new_rdata", t_rdata, 32'h11223344);
    chk("rio_new_cyc", t_cyc, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
